// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default RX FIFO depth, FIFO entry layout.
package uart_pkg;

   localparam int UART_DATA_W        = 8;
   localparam int UART_RX_FIFO_DEPTH = 16;

   // One buffered byte together with its framing-error flag.
   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-CPU byte buffer interface.
// Macro UART_RX_ERR_DROP_EN adds the drop_count signal.
interface uart_rx_fifo_if #(parameter int DEPTH = 16);
   import uart_pkg::*;

   localparam int ADDR_W = $clog2(DEPTH);

   logic [UART_DATA_W-1:0] rx_data;
   logic                   rx_done;
   logic                   rx_error;
   logic                   rd_en;
   logic                   ovf_clr;
   logic [UART_DATA_W-1:0] rd_data;
   logic                   rd_err;
   logic                   empty;
   logic                   full;
   logic [ADDR_W:0]        level;
   logic                   overflow;
   logic                   irq;
`ifdef UART_RX_ERR_DROP_EN
   logic [7:0]             drop_count;
`endif

   // Driver side: receiver plus CPU.
   modport master (
      output rx_data, rx_done, rx_error, rd_en, ovf_clr,
      input  rd_data, rd_err, empty, full, level, overflow, irq
`ifdef UART_RX_ERR_DROP_EN
      , input drop_count
`endif
   );

   // FIFO side.
   modport slave (
      input  rx_data, rx_done, rx_error, rd_en, ovf_clr,
      output rd_data, rd_err, empty, full, level, overflow, irq
`ifdef UART_RX_ERR_DROP_EN
      , output drop_count
`endif
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Shared by the RX and TX byte buffers.
module uart_fifo_mem #(
   parameter int  DEPTH   = 16,
   parameter type entry_t = logic [8:0]
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  entry_t                   wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output entry_t                   rdata
);

   entry_t mem [DEPTH];

   // Write port; contents need no reset, pointers qualify every read.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO between the UART receiver and the CPU bus.
// Macro UART_RX_ERR_DROP_EN: discard bytes flagged with rx_error and count them.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH     = UART_RX_FIFO_DEPTH,
   parameter int IRQ_LEVEL = 8
) (
   input logic           clk,
   input logic           reset,
   uart_rx_fifo_if.slave bus
);

   localparam int              ADDR_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] IRQ_LVL  = (ADDR_W+1)'(IRQ_LEVEL);

   logic            rx_done_q, rx_done_d;
   logic            push_q, push_d;
   uart_rx_entry_t  push_ent_q, push_ent_d;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
`ifdef UART_RX_ERR_DROP_EN
   logic [7:0]      drop_cnt_q, drop_cnt_d;
`endif

   logic            req;
   logic [ADDR_W:0] level;
   logic            empty, full, pop, wr_en, ovf_set;
   uart_rx_entry_t  head;

   // Occupancy and the push/pop decisions, all from registered pointers.
   always_comb begin
      level   = wr_ptr_q - rd_ptr_q;
      empty   = (level == '0);
      full    = (level == FULL_LVL);
      pop     = bus.rd_en & ~empty;
      wr_en   = push_q & (~full | pop);
      ovf_set = push_q & full & ~pop;
   end

   // One request per frame on the rising edge of rx_done; it is staged for a cycle
   // so the entry lands one edge after the rising edge is first sampled.
   always_comb begin
      rx_done_d  = bus.rx_done;
      req        = bus.rx_done & ~rx_done_q;
      push_ent_d = '{err: bus.rx_error, data: bus.rx_data};
`ifdef UART_RX_ERR_DROP_EN
      push_d     = req & ~bus.rx_error;
      drop_cnt_d = drop_cnt_q;
      if (req && bus.rx_error && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`else
      push_d     = req;
`endif
   end

   // Pointer advance and sticky overflow; a fresh overflow beats the clear.
   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{ADDR_W{1'b0}}, wr_en};
      rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
      overflow_d = overflow_q;
      if (ovf_set)          overflow_d = 1'b1;
      else if (bus.ovf_clr) overflow_d = 1'b0;
   end

   // State registers; rx_done_q resets high so a stale rx_done is never captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_done_q  <= 1'b1;
         push_q     <= 1'b0;
         push_ent_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
`ifdef UART_RX_ERR_DROP_EN
         drop_cnt_q <= '0;
`endif
      end else begin
         rx_done_q  <= rx_done_d;
         push_q     <= push_d;
         push_ent_q <= push_ent_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
`ifdef UART_RX_ERR_DROP_EN
         drop_cnt_q <= drop_cnt_d;
`endif
      end
   end

   uart_fifo_mem #(.DEPTH(DEPTH), .entry_t(uart_rx_entry_t)) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (push_ent_q),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (head)
   );

   // Head is masked while empty so the outputs are defined straight out of reset.
   assign bus.rd_data  = empty ? '0 : head.data;
`ifdef UART_RX_ERR_DROP_EN
   assign bus.rd_err     = 1'b0;
   assign bus.drop_count = drop_cnt_q;
`else
   assign bus.rd_err   = empty ? 1'b0 : head.err;
`endif
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.level    = level;
   assign bus.overflow = overflow_q;
   assign bus.irq      = (level >= IRQ_LVL);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, plus directed literal checks. Honours UART_RX_ERR_DROP_EN if defined.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int IRQ_L = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DEPTH(DEPTH)) b ();

   uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of {err,byte}; a frame is accepted one edge after
   // its rising rx_done is first seen.
   logic [8:0] mq[$];
   bit         m_prev = 1'b1;
   bit         m_pend = 1'b0;
   logic [8:0] m_pend_ent = '0;
   bit         m_ovf = 1'b0;
   int         m_drop = 0;
   bit         m_pop, m_was_full, m_set, m_req;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_prev = 1'b1;
         m_pend = 1'b0;
         m_ovf  = 1'b0;
         m_drop = 0;
      end else begin
         m_was_full = (mq.size() == DEPTH);
         m_pop      = b.rd_en && (mq.size() > 0);
         m_set      = 1'b0;
         if (m_pop) void'(mq.pop_front());
         if (m_pend) begin
            if (m_was_full && !m_pop) m_set = 1'b1;
            else mq.push_back(m_pend_ent);
         end
         if (m_set) m_ovf = 1'b1;
         else if (b.ovf_clr) m_ovf = 1'b0;
         m_req      = b.rx_done && !m_prev;
         m_prev     = b.rx_done;
         m_pend_ent = {b.rx_error, b.rx_data};
`ifdef UART_RX_ERR_DROP_EN
         if (m_req && b.rx_error) begin
            if (m_drop < 255) m_drop++;
            m_pend = 1'b0;
         end else m_pend = m_req;
`else
         m_pend = m_req;
`endif
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("m_level", b.level, mq.size());
      chk("m_empty", b.empty, mq.size() == 0);
      chk("m_full", b.full, mq.size() == DEPTH);
      chk("m_overflow", b.overflow, m_ovf);
      chk("m_irq", b.irq, mq.size() >= IRQ_L);
      if (mq.size() > 0) begin
         chk("m_rd_data", b.rd_data, mq[0][7:0]);
         chk("m_rd_err", b.rd_err, mq[0][8]);
      end
`ifdef UART_RX_ERR_DROP_EN
      chk("m_drop_count", b.drop_count, m_drop);
`endif
   end

   // Frame: rx_done drops, then rises with the byte and stays high.
   // Returns #1 after the edge at which the entry is written.
   task automatic frame(input logic [7:0] d, input logic e);
      @(posedge clk); #1 b.rx_done = 1'b0;
      @(posedge clk); #1 b.rx_data = d; b.rx_error = e; b.rx_done = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   // Same as frame, with rd_en held across the write edge.
   task automatic frame_pop(input logic [7:0] d);
      @(posedge clk); #1 b.rx_done = 1'b0;
      @(posedge clk); #1 b.rx_data = d; b.rx_error = 1'b0; b.rx_done = 1'b1;
      @(posedge clk); #1 b.rd_en = 1'b1;
      @(posedge clk); #1 b.rd_en = 1'b0;
   endtask

   task automatic pop1();
      @(posedge clk); #1 b.rd_en = 1'b1;
      @(posedge clk); #1 b.rd_en = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_level"}, b.level, 0);
      chk({tag, "_empty"}, b.empty, 1);
      chk({tag, "_full"}, b.full, 0);
      chk({tag, "_overflow"}, b.overflow, 0);
      chk({tag, "_irq"}, b.irq, 0);
      chk({tag, "_rd_err"}, b.rd_err, 0);
`ifdef UART_RX_ERR_DROP_EN
      chk({tag, "_drop_count"}, b.drop_count, 0);
`endif
   endtask

   initial begin
      b.rx_data = '0; b.rx_error = 1'b0; b.rx_done = 1'b0;
      b.rd_en = 1'b0; b.ovf_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_reset_vals("rst");

      // Three frames, popped back in order.
      frame(8'h41, 1'b0);
      frame(8'h42, 1'b0);
      frame(8'h43, 1'b0);
      chk("basic_level", b.level, 3);
      chk("basic_head0", b.rd_data, 8'h41);
      pop1();
      chk("basic_head1", b.rd_data, 8'h42);
      pop1();
      chk("basic_head2", b.rd_data, 8'h43);
      pop1();
      chk("basic_empty", b.empty, 1);

      // Fill, overflow, clear, then push coinciding with pop while full.
      for (int i = 1; i <= DEPTH; i++) frame(8'(i), 1'b0);
      chk("fill_full", b.full, 1);
      chk("fill_ovf0", b.overflow, 0);
      frame(8'hAA, 1'b0);
      chk("ovf_set", b.overflow, 1);
      chk("ovf_level", b.level, 16);
      @(posedge clk); #1 b.ovf_clr = 1'b1;
      @(posedge clk); #1 b.ovf_clr = 1'b0;
      chk("ovf_clr", b.overflow, 0);
      frame_pop(8'h77);
      chk("fullpop_level", b.level, 16);
      chk("fullpop_ovf", b.overflow, 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_data", b.rd_data, (i < DEPTH - 1) ? 8'(i + 2) : 8'h77);
         pop1();
      end
      chk("drain_empty", b.empty, 1);

      // Errored byte.
      frame(8'h55, 1'b1);
`ifdef UART_RX_ERR_DROP_EN
      chk("err_empty", b.empty, 1);
      chk("err_drop_count", b.drop_count, 1);
`else
      chk("err_rd_err", b.rd_err, 1);
      chk("err_rd_data", b.rd_data, 8'h55);
      pop1();
`endif

      // Interrupt threshold.
      for (int i = 0; i < 7; i++) frame(8'h10 + 8'(i), 1'b0);
      chk("irq_7", b.irq, 0);
      frame(8'h17, 1'b0);
      chk("irq_8_level", b.level, 8);
      chk("irq_8", b.irq, 1);
      pop1();
      chk("irq_pop", b.irq, 0);
      pop1();
      pop1();
      chk("pre_reset_level", b.level, 5);

      // Asynchronous reset mid-cycle with rx_done still high.
      @(posedge clk); #3 reset = 1'b1;
      #1;
      chk_reset_vals("async");
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("stale_done", b.empty, 1);
      frame(8'h99, 1'b0);
      chk("after_level", b.level, 1);
      chk("after_data", b.rd_data, 8'h99);
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
